// File: rtl/flash_pkg.sv
// Shared state encoding, SPI opcodes and helpers for the flash read controller.
package flash_pkg;

    typedef enum logic [2:0] {
        WAKE_CMD,
        WAKE_WAIT,
        IDLE,
        STREAM,
        DESEL,
        CMD,
        ADDR,
        DATA
    } state_e;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_WAKE = 8'hAB;

    // idx 2 selects the most significant byte, which goes out first on the wire
    function automatic logic [7:0] addr_byte(input logic [23:0] a, input logic [1:0] idx);
        case (idx)
            2'd2:    addr_byte = a[23:16];
            2'd1:    addr_byte = a[15:8];
            default: addr_byte = a[7:0];
        endcase
    endfunction

endpackage

// File: rtl/spi_byte_shift.sv
// Mode-0 SPI byte shifter: two clk cycles per bit (sck low, then sck high),
// MSB first, miso sampled at the end of the sck-high cycle.
module spi_byte_shift (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    input  logic       miso_i,
    output logic       sck_o,
    output logic       mosi_o,
    output logic       done_o,
    output logic       active_o,
    output logic [7:0] rx_byte_o
);

    logic       active_q, active_d;
    logic       sck_q, sck_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] tx_q, tx_d;
    logic [6:0] rx_q, rx_d;

    always_comb begin
        active_d = active_q;
        sck_d    = sck_q;
        cnt_d    = cnt_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        if (active_q) begin
            if (!sck_q) begin
                sck_d = 1'b1;
            end else begin
                sck_d = 1'b0;
                rx_d  = {rx_q[5:0], miso_i};
                tx_d  = {tx_q[6:0], 1'b0};
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd0) begin
                    active_d = 1'b0;
                end
            end
        end
        if (load_i) begin
            tx_d = data_i;
        end
        // a start in the done cycle chains the next byte with no gap
        if (start_i) begin
            active_d = 1'b1;
            sck_d    = 1'b0;
            cnt_d    = 3'd7;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            cnt_q    <= 3'd0;
            tx_q     <= 8'h00;
            rx_q     <= 7'h00;
        end else begin
            active_q <= active_d;
            sck_q    <= sck_d;
            cnt_q    <= cnt_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end

    assign sck_o     = sck_q;
    assign mosi_o    = tx_q[7];
    assign active_o  = active_q;
    assign done_o    = active_q & sck_q & (cnt_q == 3'd0);
    assign rx_byte_o = {rx_q, miso_i};

endmodule

// File: rtl/flash_rd_ctrl.sv
// Byte-read front end for an SPI NOR flash: wakes the part after reset, then
// serves reads, keeping a sequential stream open while addresses run consecutively.
//
// state     | meaning
// WAKE_CMD  | shifting out the release-power-down opcode
// WAKE_WAIT | csn high while the flash wakes up
// IDLE      | csn high, no stream open, accepting requests
// STREAM    | csn low mid-read, accepting requests, idle timer running
// DESEL     | csn high for the minimum deselect time
// CMD       | shifting out the read opcode
// ADDR      | shifting out the 24-bit flash address
// DATA      | shifting in one data byte
module flash_rd_ctrl
    import flash_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR    = 24'h100000,
    parameter int unsigned WAKE_WAIT    = 16,
    parameter int unsigned CSH_CYCLES   = 2,
    parameter int unsigned IDLE_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [15:0] addr,
    output logic        busy,
    output logic        rdy,
    output logic [7:0]  rdata,
    output logic        flash_sck,
    output logic        flash_csn,
    output logic        flash_mosi,
    input  logic        flash_miso,
    output logic        flash_wp_n,
    output logic        flash_hold_n
);

    localparam logic [15:0] WAKE_LOAD = 16'(WAKE_WAIT - 1);
    localparam logic [15:0] CSH_LOAD  = 16'(CSH_CYCLES - 1);
    localparam logic [15:0] IDLE_LOAD = 16'(IDLE_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] tmr_q, tmr_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [16:0] next_addr_q, next_addr_d;
    logic        fresh_q, fresh_d;
    logic        csn_q, csn_d;
    logic        rdy_q, rdy_d;
    logic [7:0]  rdata_q, rdata_d;

    logic        sh_load, sh_start, sh_done, sh_active;
    logic [7:0]  sh_data, sh_rx;
    logic [23:0] flash_addr;

    assign flash_addr = BASE_ADDR + {8'h00, addr_q};

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        byte_cnt_d  = byte_cnt_q;
        addr_d      = addr_q;
        next_addr_d = next_addr_q;
        fresh_d     = fresh_q;
        csn_d       = csn_q;
        rdy_d       = 1'b0;
        rdata_d     = rdata_q;
        sh_load     = 1'b0;
        sh_start    = 1'b0;
        sh_data     = 8'h00;
        case (state_q)
            WAKE_CMD: begin
                if (!sh_active) begin
                    sh_load  = 1'b1;
                    sh_start = 1'b1;
                    sh_data  = OP_WAKE;
                    csn_d    = 1'b0;
                end else if (sh_done) begin
                    csn_d   = 1'b1;
                    tmr_d   = WAKE_LOAD;
                    state_d = flash_pkg::WAKE_WAIT;
                end
            end
            flash_pkg::WAKE_WAIT: begin
                if (tmr_q == 16'd0) state_d = IDLE;
                else                tmr_d = tmr_q - 16'd1;
            end
            IDLE: begin
                if (req) begin
                    addr_d   = addr;
                    sh_load  = 1'b1;
                    sh_start = 1'b1;
                    sh_data  = OP_READ;
                    csn_d    = 1'b0;
                    state_d  = CMD;
                end
            end
            STREAM: begin
                // the rdy cycle is busy, so it neither samples req nor counts as idle
                if (!rdy_q) begin
                    if (req) begin
                        addr_d = addr;
                        if ({1'b0, addr} == next_addr_q) begin
                            sh_load  = 1'b1;
                            sh_start = 1'b1;
                            state_d  = DATA;
                        end else begin
                            csn_d   = 1'b1;
                            fresh_d = 1'b1;
                            tmr_d   = CSH_LOAD;
                            state_d = DESEL;
                        end
                    end else if (tmr_q == 16'd0) begin
                        csn_d   = 1'b1;
                        fresh_d = 1'b0;
                        tmr_d   = CSH_LOAD;
                        state_d = DESEL;
                    end else begin
                        tmr_d = tmr_q - 16'd1;
                    end
                end
            end
            DESEL: begin
                if (tmr_q != 16'd0) begin
                    tmr_d = tmr_q - 16'd1;
                end else if (fresh_q) begin
                    sh_load  = 1'b1;
                    sh_start = 1'b1;
                    sh_data  = OP_READ;
                    csn_d    = 1'b0;
                    state_d  = CMD;
                end else begin
                    state_d = IDLE;
                end
            end
            CMD: begin
                if (sh_done) begin
                    sh_load    = 1'b1;
                    sh_start   = 1'b1;
                    sh_data    = addr_byte(flash_addr, 2'd2);
                    byte_cnt_d = 2'd2;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                if (sh_done) begin
                    sh_load  = 1'b1;
                    sh_start = 1'b1;
                    if (byte_cnt_q == 2'd0) begin
                        state_d = DATA;
                    end else begin
                        sh_data    = addr_byte(flash_addr, byte_cnt_q - 2'd1);
                        byte_cnt_d = byte_cnt_q - 2'd1;
                    end
                end
            end
            DATA: begin
                if (sh_done) begin
                    rdy_d       = 1'b1;
                    rdata_d     = sh_rx;
                    next_addr_d = {1'b0, addr_q} + 17'd1;
                    tmr_d       = IDLE_LOAD;
                    state_d     = STREAM;
                end
            end
            default: state_d = WAKE_CMD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAKE_CMD;
            tmr_q       <= 16'd0;
            byte_cnt_q  <= 2'd0;
            addr_q      <= 16'h0000;
            next_addr_q <= 17'h00000;
            fresh_q     <= 1'b0;
            csn_q       <= 1'b1;
            rdy_q       <= 1'b0;
            rdata_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            byte_cnt_q  <= byte_cnt_d;
            addr_q      <= addr_d;
            next_addr_q <= next_addr_d;
            fresh_q     <= fresh_d;
            csn_q       <= csn_d;
            rdy_q       <= rdy_d;
            rdata_q     <= rdata_d;
        end
    end

    spi_byte_shift u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (sh_load),
        .start_i   (sh_start),
        .data_i    (sh_data),
        .miso_i    (flash_miso),
        .sck_o     (flash_sck),
        .mosi_o    (flash_mosi),
        .done_o    (sh_done),
        .active_o  (sh_active),
        .rx_byte_o (sh_rx)
    );

    assign busy         = rdy_q | ~((state_q == IDLE) | (state_q == STREAM));
    assign rdy          = rdy_q;
    assign rdata        = rdata_q;
    assign flash_csn    = csn_q;
    assign flash_wp_n   = 1'b1;
    assign flash_hold_n = 1'b1;

endmodule

// File: tb/tb_flash_rd_ctrl.sv
// Directed bench for flash_rd_ctrl with a behavioural mode-0 SPI flash model.
module tb_flash_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic        busy, rdy, flash_sck, flash_csn, flash_mosi, flash_wp_n, flash_hold_n;
    logic [7:0]  rdata;
    logic        flash_miso = 1'b0;

    int errors = 0;
    int checks = 0;

    flash_rd_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .addr         (addr),
        .busy         (busy),
        .rdy          (rdy),
        .rdata        (rdata),
        .flash_sck    (flash_sck),
        .flash_csn    (flash_csn),
        .flash_mosi   (flash_mosi),
        .flash_miso   (flash_miso),
        .flash_wp_n   (flash_wp_n),
        .flash_hold_n (flash_hold_n)
    );

    always #5 clk = ~clk;

    // ---------------- flash model ----------------
    int          m_bits = 0;
    int          m_wake = 0;
    int          m_hdr  = 0;
    int          m_k    = 0;
    logic [31:0] m_sh   = 32'h0;
    logic [7:0]  m_op   = 8'h00;
    logic [23:0] m_addr = 24'h0;
    logic [7:0]  m_byte = 8'h00;

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h100123: mem_byte = 8'h5A;
            24'h100124: mem_byte = 8'hC3;
            24'h10FFFF: mem_byte = 8'h96;
            24'h100000: mem_byte = 8'hE1;
            24'h100001: mem_byte = 8'h7E;
            24'h100002: mem_byte = 8'h81;
            default:    mem_byte = 8'h00;
        endcase
    endfunction

    always @(posedge flash_sck or posedge flash_csn) begin
        if (flash_csn) begin
            m_bits = 0;
        end else begin
            m_sh = {m_sh[30:0], flash_mosi};
            m_bits = m_bits + 1;
            if (m_bits == 8 && m_sh[7:0] == 8'hAB) m_wake = m_wake + 1;
            if (m_bits == 32) begin
                m_op   = m_sh[31:24];
                m_addr = m_sh[23:0];
                m_hdr  = m_hdr + 1;
            end
        end
    end

    always @(negedge flash_sck) begin
        if (m_bits >= 32) begin
            m_k = m_bits - 32;
            m_byte = mem_byte(m_addr + 24'(m_k / 8));
            flash_miso = m_byte[7 - (m_k % 8)];
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Issues one request; lat is the cycle index (accept cycle = 0) of the rdy pulse.
    task automatic do_read(input logic [15:0] a, output int lat, output int csn_hi,
                           output bit busy_ok, output bit rd_stable);
        logic [7:0] rd0;
        wait_idle();
        req  = 1'b1;
        addr = a;
        @(negedge clk);
        req  = 1'b0;
        addr = 16'h0000;
        lat = 1; csn_hi = 0; busy_ok = 1'b1; rd_stable = 1'b1;
        rd0 = rdata;
        while (rdy !== 1'b1 && lat < 300) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (rdata !== rd0) rd_stable = 1'b0;
            if (flash_csn === 1'b1) csn_hi++;
            @(negedge clk);
            lat++;
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
    endtask

    // Called at the negedge where rst_n is released; counts until busy falls.
    task automatic wake_measure(output int fall, output int lo, output int hi);
        fall = 0; lo = 0; hi = 0;
        do begin
            @(negedge clk);
            fall++;
            if (busy === 1'b1) begin
                if (flash_csn === 1'b0) lo++;
                else hi++;
            end
        end while (busy !== 1'b0 && fall < 200);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat, csn_hi, fall, lo, hi, n, wake0, hdr0;
        bit busy_ok, rd_stable, no_rdy;

        repeat (3) @(negedge clk);
        check("rst_csn",   flash_csn, 1'b1);
        check("rst_sck",   flash_sck, 1'b0);
        check("rst_mosi",  flash_mosi, 1'b0);
        check("rst_rdy",   rdy, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_busy",  busy, 1'b1);
        check("tie_wp",    flash_wp_n, 1'b1);
        check("tie_hold",  flash_hold_n, 1'b1);

        wake0 = m_wake;
        rst_n = 1'b1;
        wake_measure(fall, lo, hi);
        check("wake_busy_fall", fall, 33);
        check("wake_csn_low",   lo, 16);
        check("wake_csn_high",  hi, 16);
        check("wake_opcode",    m_wake - wake0, 1);

        hdr0 = m_hdr;
        do_read(16'h0123, lat, csn_hi, busy_ok, rd_stable);
        check("fresh_lat",     lat, 81);
        check("fresh_rdata",   rdata, 8'h5A);
        check("fresh_op",      m_op, 8'h03);
        check("fresh_addr",    m_addr, 24'h100123);
        check("fresh_csn_hi",  csn_hi, 0);
        check("fresh_busy",    busy_ok, 1'b1);
        check("fresh_rd_hold", rd_stable, 1'b1);
        @(negedge clk);
        check("rdy_one_cycle", rdy, 1'b0);
        check("busy_after_rdy", busy, 1'b0);
        check("csn_stream",    flash_csn, 1'b0);

        hdr0 = m_hdr;
        do_read(16'h0124, lat, csn_hi, busy_ok, rd_stable);
        check("stream_lat",    lat, 17);
        check("stream_rdata",  rdata, 8'hC3);
        check("stream_csn_hi", csn_hi, 0);
        check("stream_no_hdr", m_hdr - hdr0, 0);
        check("stream_rd_hold", rd_stable, 1'b1);

        do_read(16'hFFFF, lat, csn_hi, busy_ok, rd_stable);
        check("jump_lat",      lat, 83);
        check("jump_csn_hi",   csn_hi, 2);
        check("jump_addr",     m_addr, 24'h10FFFF);
        check("jump_rdata",    rdata, 8'h96);

        do_read(16'h0000, lat, csn_hi, busy_ok, rd_stable);
        check("wrap_lat",      lat, 83);
        check("wrap_csn_hi",   csn_hi, 2);
        check("wrap_addr",     m_addr, 24'h100000);
        check("wrap_rdata",    rdata, 8'hE1);
        check("wrap_busy",     busy_ok, 1'b1);

        // req held high through busy: one transfer, then re-sampled once idle
        wait_idle();
        req  = 1'b1;
        addr = 16'h0001;
        @(negedge clk);
        n = 1;
        while (rdy !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("hold_first_lat",   n, 17);
        check("hold_first_rdata", rdata, 8'h7E);
        @(negedge clk);
        check("hold_resample_busy", busy, 1'b0);
        @(negedge clk);
        req = 1'b0;
        check("hold_accepted", busy, 1'b1);
        n = 1;
        while (rdy !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("hold_second_lat",  n, 83);
        check("hold_second_addr", m_addr, 24'h100001);

        // stream idle timeout
        repeat (64) @(negedge clk);
        check("timeout_csn_still_low", flash_csn, 1'b0);
        @(negedge clk);
        check("timeout_csn_high", flash_csn, 1'b1);
        check("timeout_sck_low",  flash_sck, 1'b0);
        do_read(16'h0002, lat, csn_hi, busy_ok, rd_stable);
        check("after_timeout_lat",   lat, 81);
        check("after_timeout_addr",  m_addr, 24'h100002);
        check("after_timeout_rdata", rdata, 8'h81);

        // reset in the middle of a fresh read
        wait_idle();
        req  = 1'b1;
        addr = 16'h0040;
        @(negedge clk);
        req  = 1'b0;
        no_rdy = 1'b1;
        for (int c = 1; c < 30; c++) begin
            if (rdy !== 1'b0) no_rdy = 1'b0;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_csn",   flash_csn, 1'b1);
        check("midrst_sck",   flash_sck, 1'b0);
        check("midrst_mosi",  flash_mosi, 1'b0);
        check("midrst_busy",  busy, 1'b1);
        check("midrst_rdata", rdata, 8'h00);
        repeat (3) begin
            @(negedge clk);
            if (rdy !== 1'b0) no_rdy = 1'b0;
        end
        check("midrst_no_rdy", no_rdy, 1'b1);
        wake0 = m_wake;
        rst_n = 1'b1;
        wake_measure(fall, lo, hi);
        check("rewake_busy_fall", fall, 33);
        check("rewake_csn_low",   lo, 16);
        check("rewake_opcode",    m_wake - wake0, 1);
        do_read(16'h0123, lat, csn_hi, busy_ok, rd_stable);
        check("rewake_read_lat",   lat, 81);
        check("rewake_read_rdata", rdata, 8'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flash_rd_ctrl.md
FLASH_RD_CTRL -- requirements
Module: flash_rd_ctrl

Interface
REQ-001 Parameter BASE_ADDR, 24'h100000, flash byte offset added to the 16-bit request address.
REQ-002 Parameter WAKE_WAIT, 16, clk cycles csn stays high after the release-power-down command.
REQ-003 Parameter CSH_CYCLES, 2, minimum clk cycles csn stays high between transactions (legal range 2..15).
REQ-004 Parameter IDLE_TIMEOUT, 64, idle clk cycles before an open read stream is closed.
REQ-005 clk  in  1  system clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 req  in  1  read request; sampled only while busy=0.
REQ-008 addr  in  16  cartridge byte address; captured with an accepted req.
REQ-009 busy  out  1  high while a request cannot be accepted.
REQ-010 rdy  out  1  one-cycle pulse: rdata is valid.
REQ-011 rdata  out  8  read byte; holds its value until the next rdy.
REQ-012 flash_sck  out  1  SPI clock, mode 0.
REQ-013 flash_csn  out  1  SPI chip select, active-low.
REQ-014 flash_mosi  out  1  SPI data to flash (IO0).
REQ-015 flash_miso  in  1  SPI data from flash (IO1).
REQ-016 flash_wp_n, flash_hold_n  out  1 each  tied high.

Function
REQ-017 The states SHALL be WAKE_CMD, WAKE_WAIT, IDLE, STREAM, DESEL, CMD, ADDR, DATA.
REQ-018 Each SPI bit SHALL take 2 clk cycles: sck low with mosi updated, then sck high with miso sampled at the end of that cycle; bits are MSB first.
REQ-019 After reset the block SHALL send opcode 0xAB in WAKE_CMD (16 cycles), raise csn for WAKE_WAIT cycles, then enter IDLE; busy=1 throughout.
REQ-020 A req is accepted in the cycle that req=1 and busy=0 (cycle 0); busy SHALL be 1 from cycle 1 until the rdy cycle inclusive.
REQ-021 Fresh read from IDLE: csn low from cycle 1; opcode 0x03 plus a 24-bit address (BASE_ADDR + addr, mod 2^24) over cycles 1-64; data over cycles 65-80; rdy pulses at cycle 81.
REQ-022 After rdy, csn SHALL stay low and the block SHALL enter STREAM with next_addr = captured addr + 1 (17-bit compare, no 16-bit wrap).
REQ-023 In STREAM, a req with addr == next_addr SHALL clock 8 data bits only (cycles 1-16), with rdy at cycle 17.
REQ-024 In STREAM, a req with any other addr, including wrap 0xFFFF to 0x0000, SHALL enter DESEL (csn high for CSH_CYCLES) and then run the fresh sequence; rdy arrives at cycle 81+CSH_CYCLES.
REQ-025 STREAM with no req for IDLE_TIMEOUT consecutive cycles SHALL raise csn and enter IDLE after CSH_CYCLES.
REQ-026 rdata SHALL update only in the rdy cycle.
REQ-027 req held high through busy SHALL NOT queue; it is re-sampled at the first busy=0 cycle.
REQ-028 sck SHALL be low whenever csn is high.

Reset
REQ-029 Reset SHALL asynchronously force csn=1, sck=0, mosi=0, rdy=0, rdata=8'h00, busy=1, and state=WAKE_CMD; the wake sequence SHALL restart on release.
REQ-030 Reset asserted mid-transaction SHALL abort the transaction with no rdy pulse.

Structure
REQ-031 Package flash_pkg SHALL hold the state enum and opcodes OP_READ=8'h03 and OP_WAKE=8'hAB.
REQ-032 Sub-module spi_byte_shift SHALL perform the 8-bit shift and bit count, with load, start and done handshake; the parent FSM sequences it.

Verification
REQ-033 Release reset -> 0xAB appears on mosi over 16 cycles; csn high for 16 cycles; busy falls after that.
REQ-034 Flash model holds 0x5A at 0x100123; req addr=0x0123 -> mosi 0x03 0x10 0x01 0x23; rdy at cycle 81; rdata=0x5A.
REQ-035 Then req addr=0x0124 -> no csn pulse; rdy at cycle 17 with the byte at 0x100124.
REQ-036 Stream at 0xFFFF, then req 0x0000 -> csn high for 2 cycles; fresh address 0x100000; rdy at cycle 83.
REQ-037 Stream open, no req for 64 cycles -> csn rises; the next req takes the fresh 81-cycle path.
REQ-038 rst_n low at cycle 30 of a read -> csn=1 immediately; no rdy; wake sequence repeats.
